// File: rtl/prg_monitor.sv
// -----------------------------------------------------------------------------
// prg_monitor
//
// Byte-command monitor engine for the programming port of the CPU memory.
// A byte stream from the UART receiver is decoded into write (0x57 addr data),
// read (0x52 addr) and dump (0x44 addr len) commands. The engine performs the
// memory accesses and returns acknowledgements / read data to the UART
// transmitter over a valid/ready handshake. Runs on the same clock as the
// memory's prg_clock.
//
// Ports:
//   clock       monitor clock (also the memory prg_clock)
//   reset_n     asynchronous active-low reset
//   rx_data     received byte, qualified by rx_valid
//   rx_valid    one-cycle strobe; no backpressure towards the receiver
//   tx_data     byte to the UART transmitter, stable while tx_valid is high
//   tx_valid    tx_data valid; held until tx_ready is seen at a rising edge
//   tx_ready    transmitter accepts the byte
//   prg_we      memory write enable (single-cycle pulse)
//   prg_MA      memory address
//   prg_WD      memory write data
//   prg_RD      memory read data
//   busy        high whenever the engine is not idle
//   cmd_err     one-cycle pulse on an unknown opcode
//   rx_overrun  one-cycle pulse when a byte arrives that cannot be accepted
// -----------------------------------------------------------------------------
module prg_monitor (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       prg_we,
    output logic [7:0] prg_MA,
    output logic [7:0] prg_WD,
    input  logic [7:0] prg_RD,
    output logic       busy,
    output logic       cmd_err,
    output logic       rx_overrun
);

    localparam logic [7:0] OPC_WRITE = 8'h57;
    localparam logic [7:0] OPC_READ  = 8'h52;
    localparam logic [7:0] OPC_DUMP  = 8'h44;
    localparam logic [7:0] ACK_BYTE  = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_ARG,
        S_WRITE,
        S_READ,
        S_SEND
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_READ,
        OP_DUMP
    } op_t;

    state_t     state;
    op_t        op;
    logic [8:0] remaining;   // bytes still to send in a dump; 256 fits in 9 bits
    logic       wait_cnt;    // second READ cycle marker

    // NOTE: every register here is updated with non-blocking assignments so
    // all branches see the pre-edge values of state, op and counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            op         <= OP_WRITE;
            remaining  <= 9'd0;
            wait_cnt   <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            prg_we     <= 1'b0;
            prg_MA     <= 8'h00;
            prg_WD     <= 8'h00;
            busy       <= 1'b0;
            cmd_err    <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            // Pulse outputs default low; the branches below raise them.
            cmd_err    <= 1'b0;
            rx_overrun <= 1'b0;
            prg_we     <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        case (rx_data)
                            OPC_WRITE: begin
                                op    <= OP_WRITE;
                                state <= S_GET_ADDR;
                                busy  <= 1'b1;
                            end
                            OPC_READ: begin
                                op    <= OP_READ;
                                state <= S_GET_ADDR;
                                busy  <= 1'b1;
                            end
                            OPC_DUMP: begin
                                op    <= OP_DUMP;
                                state <= S_GET_ADDR;
                                busy  <= 1'b1;
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
                end

                S_GET_ADDR: begin
                    if (rx_valid) begin
                        prg_MA <= rx_data;
                        if (op == OP_READ) begin
                            wait_cnt <= 1'b0;
                            state    <= S_READ;
                        end else begin
                            state <= S_GET_ARG;
                        end
                    end
                end

                S_GET_ARG: begin
                    if (rx_valid) begin
                        if (op == OP_WRITE) begin
                            prg_WD <= rx_data;
                            prg_we <= 1'b1;   // high for the whole WRITE cycle
                            state  <= S_WRITE;
                        end else begin
                            // A length byte of zero means a full 256-byte dump.
                            remaining <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                            wait_cnt  <= 1'b0;
                            state     <= S_READ;
                        end
                    end
                end

                S_WRITE: begin
                    rx_overrun <= rx_valid;
                    tx_data    <= ACK_BYTE;
                    tx_valid   <= 1'b1;
                    state      <= S_SEND;
                end

                S_READ: begin
                    // prg_MA is held for both cycles so the synchronous
                    // memory read has settled by the second edge.
                    rx_overrun <= rx_valid;
                    if (wait_cnt) begin
                        tx_data  <= prg_RD;
                        tx_valid <= 1'b1;
                        wait_cnt <= 1'b0;
                        state    <= S_SEND;
                    end else begin
                        wait_cnt <= 1'b1;
                    end
                end

                S_SEND: begin
                    rx_overrun <= rx_valid;
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        if (op == OP_DUMP && remaining != 9'd1) begin
                            remaining <= remaining - 9'd1;
                            prg_MA    <= prg_MA + 8'd1;   // wraps 0xFF -> 0x00
                            wait_cnt  <= 1'b0;
                            state     <= S_READ;
                        end else begin
                            remaining <= 9'd0;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prg_monitor.sv
// -----------------------------------------------------------------------------
// tb_prg_monitor
//
// Self-checking bench for prg_monitor. Provides a synchronous-read memory on
// the programming port, a shadow model of that memory's intended contents,
// directed timing sequences, a table of write/read vectors and randomized
// command traffic with random transmitter stalls.
// -----------------------------------------------------------------------------
module tb_prg_monitor;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       prg_we;
    logic [7:0] prg_MA;
    logic [7:0] prg_WD;
    logic [7:0] prg_RD;
    logic       busy;
    logic       cmd_err;
    logic       rx_overrun;

    prg_monitor dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .prg_we     (prg_we),
        .prg_MA     (prg_MA),
        .prg_WD     (prg_WD),
        .prg_RD     (prg_RD),
        .busy       (busy),
        .cmd_err    (cmd_err),
        .rx_overrun (rx_overrun)
    );

    always #5 clock = ~clock;

    // Memory attached to the programming port: synchronous write and read.
    bit [7:0] mem [256];
    always @(posedge clock) begin
        if (prg_we === 1'b1) mem[prg_MA] <= prg_WD;
        prg_RD <= mem[prg_MA];
    end

    // Shadow of what the memory should hold after each command.
    bit [7:0] model_mem [256];

    int we_count = 0;
    always @(negedge clock) if (prg_we === 1'b1) we_count++;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int K_W = 0;
    localparam int K_R = 1;

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] arg;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clock);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Waits (bounded) for a transmitted byte; returns after its handshake edge.
    task automatic get_reply(input bit stall, output logic [7:0] b);
        bit got = 1'b0;
        b = 8'h00;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            tx_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (tx_valid === 1'b1 && tx_ready) begin
                b   = tx_data;
                got = 1'b1;
            end
        end
        if (!got) check("reply_timeout", {31'd0, got}, 32'd1);
        @(negedge clock);
        tx_ready = 1'b1;
    endtask

    task automatic wait_tx_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clock);
            if (tx_valid === 1'b1) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input bit stall,
                            input logic [7:0] exp_ack);
        logic [7:0] b;
        int we0 = we_count;
        send_byte(8'h57);
        send_byte(a);
        send_byte(d);
        get_reply(stall, b);
        check("write_ack", b, exp_ack);
        check("write_we_pulses", we_count - we0, 1);
        check("write_busy_done", busy, 0);
        model_mem[a] = d;
    endtask

    task automatic do_read(input logic [7:0] a, input bit stall, input logic [7:0] exp);
        logic [7:0] b;
        int we0 = we_count;
        send_byte(8'h52);
        send_byte(a);
        get_reply(stall, b);
        check("read_data", b, exp);
        check("read_no_we", we_count - we0, 0);
        check("read_busy_done", busy, 0);
    endtask

    task automatic do_dump(input logic [7:0] a, input logic [7:0] len, input bit stall);
        logic [7:0] b;
        int we0 = we_count;
        int n = (len == 8'h00) ? 256 : int'(len);
        send_byte(8'h44);
        send_byte(a);
        send_byte(len);
        for (int i = 0; i < n; i++) begin
            get_reply(stall, b);
            check("dump_byte", b, model_mem[(int'(a) + i) % 256]);
        end
        check("dump_no_we", we_count - we0, 0);
        check("dump_busy_done", busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [8];
        logic [7:0] b;
        int we0;

        vecs[0] = '{K_W, 8'hFE, 8'h11, 8'h06};
        vecs[1] = '{K_W, 8'hFF, 8'h22, 8'h06};
        vecs[2] = '{K_W, 8'h00, 8'h33, 8'h06};
        vecs[3] = '{K_R, 8'hFE, 8'h00, 8'h11};
        vecs[4] = '{K_R, 8'hFF, 8'h00, 8'h22};
        vecs[5] = '{K_R, 8'h00, 8'h00, 8'h33};
        vecs[6] = '{K_W, 8'h80, 8'h5A, 8'h06};
        vecs[7] = '{K_R, 8'h80, 8'h00, 8'h5A};

        // ---- reset state ----
        repeat (3) @(negedge clock);
        check("rst_prg_we", prg_we, 0);
        check("rst_prg_MA", prg_MA, 0);
        check("rst_prg_WD", prg_WD, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_err", cmd_err, 0);
        check("rst_rx_overrun", rx_overrun, 0);
        reset_n = 1'b1;

        // ---- directed write with exact timing ----
        we0 = we_count;
        send_byte(8'h57);
        check("w_busy_after_opcode", busy, 1);
        send_byte(8'h10);
        send_byte(8'hA5);
        check("w_we_high", prg_we, 1);
        check("w_MA", prg_MA, 8'h10);
        check("w_WD", prg_WD, 8'hA5);
        check("w_txv_not_yet", tx_valid, 0);
        @(negedge clock);
        check("w_we_low", prg_we, 0);
        check("w_txv", tx_valid, 1);
        check("w_ack", tx_data, 8'h06);
        @(negedge clock);
        check("w_idle_busy", busy, 0);
        check("w_idle_txv", tx_valid, 0);
        check("w_one_pulse", we_count - we0, 1);
        check("w_mem", mem[8'h10], 8'hA5);
        model_mem[8'h10] = 8'hA5;

        // ---- read with exact timing ----
        we0 = we_count;
        send_byte(8'h52);
        send_byte(8'h10);
        check("r_txv_edge1", tx_valid, 0);
        @(negedge clock);
        check("r_txv_edge2", tx_valid, 0);
        check("r_MA_held", prg_MA, 8'h10);
        @(negedge clock);
        check("r_txv_edge3", tx_valid, 1);
        check("r_data", tx_data, 8'hA5);
        @(negedge clock);
        check("r_idle_busy", busy, 0);
        check("r_no_we", we_count - we0, 0);

        // ---- table-driven writes and reads ----
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].kind == K_W) do_write(vecs[i].addr, vecs[i].arg, 1'b0, vecs[i].exp);
            else                     do_read(vecs[i].addr, 1'b0, vecs[i].exp);
        end

        // ---- dump with address wrap ----
        do_dump(8'hFE, 8'h03, 1'b0);

        // ---- backpressure during a dump, with an overrun byte ----
        tx_ready = 1'b0;
        send_byte(8'h44);
        send_byte(8'hFE);
        send_byte(8'h02);
        wait_tx_valid("bp_first_valid");
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            rx_valid = (c == 3);
            rx_data  = (c == 3) ? 8'h57 : 8'h00;
            check("bp_txv_held", tx_valid, 1);
            check("bp_data_held", tx_data, 8'h11);
            check("bp_MA_held", prg_MA, 8'hFE);
            check("bp_overrun", rx_overrun, (c == 4) ? 1 : 0);
        end
        rx_valid = 1'b0;
        get_reply(1'b0, b);
        check("bp_byte0", b, 8'h11);
        get_reply(1'b0, b);
        check("bp_byte1", b, 8'h22);
        check("bp_busy_done", busy, 0);
        do_read(8'h10, 1'b0, 8'hA5);

        // ---- unknown opcode ----
        send_byte(8'h00);
        check("err_pulse", cmd_err, 1);
        check("err_busy", busy, 0);
        @(negedge clock);
        check("err_pulse_end", cmd_err, 0);
        check("err_busy_after", busy, 0);
        do_read(8'h10, 1'b0, 8'hA5);

        // ---- reset in the middle of a 256-byte dump ----
        tx_ready = 1'b0;
        send_byte(8'h44);
        send_byte(8'h20);
        send_byte(8'h00);
        wait_tx_valid("mid_valid");
        #2 reset_n = 1'b0;
        #1;
        check("mr_tx_valid", tx_valid, 0);
        check("mr_tx_data", tx_data, 0);
        check("mr_busy", busy, 0);
        check("mr_prg_MA", prg_MA, 0);
        check("mr_prg_WD", prg_WD, 0);
        check("mr_prg_we", prg_we, 0);
        @(negedge clock);
        reset_n  = 1'b1;
        tx_ready = 1'b1;
        do_read(8'h10, 1'b0, 8'hA5);

        // ---- randomized traffic against the shadow model ----
        for (int i = 0; i < 60; i++) begin
            int kind = int'($urandom_range(0, 2));
            logic [7:0] a = 8'($urandom);
            if (kind == 0)      do_write(a, 8'($urandom), 1'b1, 8'h06);
            else if (kind == 1) do_read(a, 1'b1, model_mem[a]);
            else                do_dump(a, 8'($urandom_range(1, 5)), 1'b1);
        end
        do_dump(8'($urandom), 8'h00, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prg_monitor.md
# prg_monitor

Byte-command monitor engine that drives the programming port of the CPU memory block (prg_we / prg_MA / prg_WD / prg_RD). It takes a byte stream from the UART receiver, decodes write, read and dump commands, and performs the memory accesses. It returns read data and acknowledgements to the UART transmitter over a valid/ready handshake. It lives in the monitor clock domain, on the same clock as the memory's prg_clock.

## Interface
- Parameters: none.
- clock  in  1  monitor clock; also drives memory prg_clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe qualifying rx_data; there is no backpressure.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid; held until accepted.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready at a rising edge.
- prg_we  out  1  memory write enable.
- prg_MA  out  8  memory address.
- prg_WD  out  8  memory write data.
- prg_RD  in  8  memory read data.
- busy  out  1  high in every state except IDLE.
- cmd_err  out  1  one-cycle pulse when an opcode is unknown.
- rx_overrun  out  1  one-cycle pulse when a byte arrives while it cannot be accepted.

## Operation
- Commands are raw bytes:
  - 0x57 addr data: write one byte, then reply 0x06.
  - 0x52 addr: read one byte, then reply with the data.
  - 0x44 addr len: dump len bytes starting at addr; len = 0x00 means 256 bytes.
- Byte acceptance:
  - Bytes are accepted only in IDLE, GET_ADDR and GET_ARG.
  - A rx_valid in any other state drops the byte and pulses rx_overrun.
- Unknown opcode in IDLE: pulse cmd_err, drop the byte, stay in IDLE.
- States and transitions:
  - IDLE -> GET_ADDR on a valid opcode; the opcode is latched.
  - GET_ADDR -> READ on R. GET_ADDR -> GET_ARG on W or D. The address is latched into prg_MA.
  - GET_ARG -> WRITE on W, with the byte latched into prg_WD.
  - GET_ARG -> READ on D, with the byte latched into the 9-bit remaining count (0x00 is loaded as 256).
  - WRITE: prg_we high for exactly this one cycle, then -> SEND with tx_data = 0x06.
  - READ: a 2-cycle wait counter; prg_MA is held stable. On the 2nd cycle prg_RD is captured into tx_data, then -> SEND.
  - SEND: tx_valid high until handshake. On handshake:
    - R/W -> IDLE.
    - D: decrement remaining. If it is now 0 -> IDLE. Otherwise prg_MA += 1 (mod 256, 0xFF wraps to 0x00) -> READ.
- prg_we is 0 in every state except WRITE. A dump never writes.
- There is no inter-byte timeout. A partial command waits indefinitely.
- Reset (asynchronous, any state, including mid-dump or during tx_valid):
  - All outputs go to 0: prg_we=0, prg_MA=0x00, prg_WD=0x00, tx_data=0x00, tx_valid=0, busy=0, cmd_err=0, rx_overrun=0.
  - State goes to IDLE and the remaining count to 0.

## Timing
- All state updates and outputs are registered on rising clock. There are no combinational paths from inputs to outputs.
- Write: prg_we is asserted in the cycle after the data byte's rx_valid edge. tx_valid rises on the following edge.
- Read: tx_valid rises 3 edges after the address byte is accepted: 1 edge to enter READ, then 2 wait edges. prg_RD is sampled exactly at the 2nd READ edge.
- Dump: per byte, handshake edge -> 2 READ cycles -> tx_valid. Minimum 3 cycles/byte with tx_ready tied high.
- tx_data is stable while tx_valid is high. tx_valid is never withdrawn without a handshake, except on reset.
- busy asserts on the edge that leaves IDLE and deasserts on the edge that re-enters IDLE.

## Test plan
- Write: rx 0x57,0x10,0xA5 with tx_ready=1:
  - one prg_we pulse with prg_MA=0x10, prg_WD=0xA5.
  - tx 0x06.
  - memory[0x10]=0xA5.
- Read after write: rx 0x52,0x10:
  - tx_data=0xA5 exactly 3 edges after the address byte.
  - prg_we never high.
- Dump with wrap: preload 0xFE=0x11, 0xFF=0x22, 0x00=0x33, then rx 0x44,0xFE,0x03:
  - tx 0x11,0x22,0x33 in order.
  - IDLE after the 3rd handshake.
- Backpressure: hold tx_ready=0 for 10 cycles during a dump:
  - tx_valid and tx_data held, prg_MA unchanged.
  - An extra rx byte during the stall pulses rx_overrun and is dropped.
- Error: rx 0x00 in IDLE -> cmd_err single-cycle pulse, busy stays 0. A following 0x52,0x10 read still works.
- Reset mid-dump: assert reset_n=0 while tx_valid=1 with len=0x00 -> all outputs 0 immediately. After release, a new R command works normally.
